txt_write_scheduler: RTL and testbench
======================================

// Module: txt_write_scheduler
// PURPOSE
//  Sequences all character writes into the txtScreen character RAM (addr/data/nWr port).
//  Arbitrates two requesters (req0 = score updater, req1 = message writer) and runs a
//  built-in clear-screen engine.
//  Every write uses the fixed 3-phase nWr strobe: SETUP, then STROBE, then HOLD.
//  Sits in vga_controller between the game logic and txtScreen, in the iVGA_CLK domain.
// PARAMETERS
//  SCREEN_CHARS   2400  character cells cleared by the clear engine (80x30)
//  CLEAR_CHAR     8'h20 code written by the clear engine (space)
//  STROBE_CYCLES  1     cycles nWr is held low per write (1..15)
//  ADDR_W         12    character address width
// PORTS
//  iVGA_CLK   in   1       pixel clock; all logic is on its rising edge
//  reset      in   1       synchronous reset, active-high
//  clr_req    in   1       level request to clear the whole screen
//  clr_done   out  1       one-cycle pulse after the last clear write's HOLD phase
//  req0       in   1       requester 0 write request (level, held until ack0)
//  addr0      in   ADDR_W  requester 0 character address
//  data0      in   8       requester 0 character code
//  ack0       out  1       one-cycle pulse: requester 0 write completed
//  req1/addr1/data1/ack1   same as requester 0, for requester 1
//  busy       out  1       high in every state except IDLE
//  oAddr      out  ADDR_W  to txtScreen addr
//  oData      out  8       to txtScreen data
//  oNwr       out  1       to txtScreen nWr (active-low write strobe)
// BEHAVIOUR
//  Reset values: oAddr=0, oData=0, oNwr=1, ack0=ack1=0, clr_done=0, busy=0.
//   Round-robin pointer is reset to favour req0.
//  Reset mid-operation: the current write is aborted and oNwr=1 on the next edge.
//   The clear engine does not resume.
//  FSM states: IDLE, SETUP, STROBE, HOLD. A clr_mode flag selects clear or single write.
//  IDLE: requests are sampled. Priority: clr_req, then round-robin between req0 and req1.
//   If only one request is pending, it is granted.
//   If both are pending, the requester not granted last time wins.
//   On a grant, addr/data are latched and the FSM goes to SETUP.
//  SETUP (1 cycle): oAddr/oData valid and oNwr=1.
//  STROBE (STROBE_CYCLES cycles): oNwr=0; oAddr/oData stable.
//  HOLD (1 cycle): oNwr=1; oAddr/oData stable.
//   The ackN of the granted requester pulses high in this same cycle.
//  Single write: grant sampled at cycle T, SETUP at T+1, ack at T+2+STROBE_CYCLES.
//   IDLE follows, so back-to-back writes take 3+STROBE_CYCLES cycles each.
//  Clear: addresses run 0..SCREEN_CHARS-1 with data CLEAR_CHAR.
//   HOLD goes directly to SETUP for the next address (2+STROBE_CYCLES cycles per char).
//   After the HOLD for SCREEN_CHARS-1: clr_done pulses in the following cycle, then IDLE.
//   The clear engine completes without interruption. req0/req1 wait and are not acked.
//   clr_req still high at IDLE starts a new clear (the requester drops it on clr_done).
//  clr_req during a single write: the current write completes and is acked.
//   The clear wins at the next IDLE.
//  A request dropped before its ack: behaviour is undefined.
//   The latched addr/data are still written, and the ack still pulses.
//  Address counter width is ADDR_W. The clear counter does not wrap and stops at SCREEN_CHARS-1.
//  Requester inputs are used only when sampled in IDLE. Later changes do not affect the write.
// STRUCTURE
//  Package vga_txt_pkg holds:
//   - the state enum (IDLE/SETUP/STROBE/HOLD)
//   - SCREEN_CHARS, CLEAR_CHAR and ADDR_W defaults
//   - the score/message screen address constants (12'h05C, 12'h06B)
//  Sub-module txt_rr_arbiter: 2-way round-robin. Inputs req[1:0] and a grant enable.
//   Outputs a one-hot grant and updates its last-grant pointer on grant.
//  The top holds the FSM, strobe counter, clear counter and output registers.
// TESTING
//  1. req0 with addr0=12'h05C, data0=8'h33, STROBE_CYCLES=1
//     -> SETUP at T+1 (oNwr=1, oAddr=05C, oData=33), oNwr=0 at T+2, HOLD and ack0 at T+3.
//  2. req0 and req1 asserted together and held for 4 writes
//     -> grants alternate 0,1,0,1; each ack pulses once; no write overlaps.
//  3. clr_req pulsed at reset exit
//     -> 2400 writes of 8'h20 at addresses 0..2399, 3 cycles each.
//     -> clr_done pulses exactly once, 7201 cycles after the grant edge.
//  4. req1 asserted during a clear
//     -> no ack1 until after clr_done; then the req1 write follows; oNwr shows no glitch.
//  5. reset asserted while in STROBE
//     -> next edge gives oNwr=1, busy=0, all acks 0.
//     -> no ack for the aborted write; the next req0 is granted first.
//  6. STROBE_CYCLES=3, single req1
//     -> oNwr low for exactly 3 cycles; ack1 at T+5.

Source files
------------

// File: rtl/vga_txt_pkg.sv
// Shared types and constants for the txtScreen write path.
// Holds the scheduler state encoding, default sizes and fixed screen addresses.
package vga_txt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } txt_state_e;

  localparam int          SCREEN_CHARS_DEF = 2400;
  localparam logic [7:0]  CLEAR_CHAR_DEF   = 8'h20;
  localparam int          ADDR_W_DEF       = 12;

  localparam logic [11:0] SCORE_ADDR = 12'h05C;
  localparam logic [11:0] MSG_ADDR   = 12'h06B;

endpackage

// File: rtl/txt_write_scheduler_if.sv
// Requester/txtScreen bundle for the write scheduler.
// master = game-logic side, slave = the scheduler itself.
interface txt_write_scheduler_if
  import vga_txt_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              clr_req;
  logic              clr_done;
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [7:0]        data0;
  logic              ack0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [7:0]        data1;
  logic              ack1;
  logic              busy;
  logic [ADDR_W-1:0] oAddr;
  logic [7:0]        oData;
  logic              oNwr;

  modport master (
    output clr_req, req0, addr0, data0, req1, addr1, data1,
    input  clr_done, ack0, ack1, busy, oAddr, oData, oNwr
  );

  modport slave (
    input  clr_req, req0, addr0, data0, req1, addr1, data1,
    output clr_done, ack0, ack1, busy, oAddr, oData, oNwr
  );
endinterface

// File: rtl/txt_rr_arbiter.sv
// Two-way round-robin arbiter: with both requests pending, the side not
// granted last time wins. Pointer only moves when a grant is taken.
module txt_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);
  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  assign last_d = (en_i && (gnt_o != 2'b00)) ? gnt_o[1] : last_q;

  // Reset value "last was 1" so requester 0 is favoured first.
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
endmodule

// File: rtl/txt_write_scheduler.sv
// Sequences SETUP/STROBE/HOLD nWr writes into txtScreen for two requesters
// and a full-screen clear engine, all on the iVGA_CLK rising edge.
module txt_write_scheduler
  import vga_txt_pkg::*;
#(
  parameter int         SCREEN_CHARS  = SCREEN_CHARS_DEF,
  parameter logic [7:0] CLEAR_CHAR    = CLEAR_CHAR_DEF,
  parameter int         STROBE_CYCLES = 1,
  parameter int         ADDR_W        = ADDR_W_DEF
) (
  input  logic                 iVGA_CLK,
  input  logic                 reset,
  txt_write_scheduler_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(SCREEN_CHARS - 1);
  localparam logic [3:0]        STROBE_LAST = 4'(STROBE_CYCLES - 1);

  txt_state_e        state_q, state_d;
  logic              clr_mode_q, clr_mode_d;
  logic              sel_q, sel_d;
  logic [3:0]        strb_cnt_q, strb_cnt_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              nwr_q, nwr_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              done_q, done_d;
  logic [1:0]        gnt;
  logic              arb_en;

  // The clear request outranks both requesters, so it also blocks the arbiter.
  assign arb_en = (state_q == ST_IDLE) && !bus.clr_req;

  txt_rr_arbiter u_arb (
    .clk   (iVGA_CLK),
    .rst   (reset),
    .req_i ({bus.req1, bus.req0}),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      clr_mode_q <= 1'b0;
      sel_q      <= 1'b0;
      strb_cnt_q <= '0;
      clr_cnt_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      nwr_q      <= 1'b1;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_mode_q <= clr_mode_d;
      sel_q      <= sel_d;
      strb_cnt_q <= strb_cnt_d;
      clr_cnt_q  <= clr_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      nwr_q      <= nwr_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_mode_d = clr_mode_q;
    sel_d      = sel_q;
    strb_cnt_d = strb_cnt_q;
    clr_cnt_d  = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d    = ST_SETUP;
          clr_mode_d = 1'b1;
          clr_cnt_d  = '0;
        end else if (gnt != 2'b00) begin
          state_d    = ST_SETUP;
          clr_mode_d = 1'b0;
          sel_d      = gnt[1];
        end
      end
      ST_SETUP: begin
        state_d    = ST_STROBE;
        strb_cnt_d = STROBE_LAST;
      end
      ST_STROBE: begin
        if (strb_cnt_q == 4'd0) state_d = ST_HOLD;
        else                    strb_cnt_d = strb_cnt_q - 4'd1;
      end
      ST_HOLD: begin
        // Clear runs back-to-back without revisiting IDLE until the last cell.
        if (clr_mode_q && (clr_cnt_q != LAST_ADDR)) begin
          state_d   = ST_SETUP;
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if ((state_q == ST_IDLE) && (state_d == ST_SETUP)) begin
      if (clr_mode_d) begin
        addr_d = '0;
        data_d = CLEAR_CHAR;
      end else if (sel_d) begin
        addr_d = bus.addr1;
        data_d = bus.data1;
      end else begin
        addr_d = bus.addr0;
        data_d = bus.data0;
      end
    end else if ((state_q == ST_HOLD) && (state_d == ST_SETUP)) begin
      addr_d = clr_cnt_d;
    end
    nwr_d  = (state_d != ST_STROBE);
    ack0_d = (state_d == ST_HOLD) && !clr_mode_q && !sel_q;
    ack1_d = (state_d == ST_HOLD) && !clr_mode_q &&  sel_q;
    done_d = (state_q == ST_HOLD) && clr_mode_q && (clr_cnt_q == LAST_ADDR);
  end

  assign bus.oAddr    = addr_q;
  assign bus.oData    = data_q;
  assign bus.oNwr     = nwr_q;
  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.clr_done = done_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_txt_write_scheduler.sv
// Directed bench for txt_write_scheduler: single writes, round-robin,
// clear engine, clear vs. requester, reset abort and a 3-cycle strobe build.
module tb_txt_write_scheduler;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  txt_write_scheduler_if #(.ADDR_W(12)) bif1 ();
  txt_write_scheduler_if #(.ADDR_W(12)) bif3 ();

  txt_write_scheduler #(.STROBE_CYCLES(1), .ADDR_W(12)) u_s1 (
    .iVGA_CLK (clk),
    .reset    (rst),
    .bus      (bif1.slave)
  );

  txt_write_scheduler #(.STROBE_CYCLES(3), .ADDR_W(12)) u_s3 (
    .iVGA_CLK (clk),
    .reset    (rst),
    .bus      (bif3.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n, nw, nd, bad, done_at, ack_at, glitch, early, lows, first_low;
    logic prev_nwr;
    logic [11:0] ack_addr;
    logic [7:0]  ack_data;

    rst = 1'b1;
    bif1.clr_req = 1'b0; bif1.req0 = 1'b0; bif1.req1 = 1'b0;
    bif1.addr0 = '0; bif1.data0 = '0; bif1.addr1 = '0; bif1.data1 = '0;
    bif3.clr_req = 1'b0; bif3.req0 = 1'b0; bif3.req1 = 1'b0;
    bif3.addr0 = '0; bif3.data0 = '0; bif3.addr1 = '0; bif3.data1 = '0;
    repeat (3) step();

    chk("rst_addr", bif1.oAddr, 12'h000);
    chk("rst_data", bif1.oData, 8'h00);
    chk("rst_nwr", bif1.oNwr, 1'b1);
    chk("rst_ack0", bif1.ack0, 1'b0);
    chk("rst_ack1", bif1.ack1, 1'b0);
    chk("rst_done", bif1.clr_done, 1'b0);
    chk("rst_busy", bif1.busy, 1'b0);
    chk("rst_nwr_s3", bif3.oNwr, 1'b1);

    // Single req0 write, strobe of one cycle
    rst = 1'b0;
    bif1.addr0 = 12'h05C; bif1.data0 = 8'h33; bif1.req0 = 1'b1;
    step();
    chk("t1_setup_nwr", bif1.oNwr, 1'b1);
    chk("t1_setup_addr", bif1.oAddr, 12'h05C);
    chk("t1_setup_data", bif1.oData, 8'h33);
    chk("t1_setup_busy", bif1.busy, 1'b1);
    chk("t1_setup_ack0", bif1.ack0, 1'b0);
    step();
    chk("t1_strobe_nwr", bif1.oNwr, 1'b0);
    chk("t1_strobe_ack0", bif1.ack0, 1'b0);
    step();
    chk("t1_hold_nwr", bif1.oNwr, 1'b1);
    chk("t1_hold_ack0", bif1.ack0, 1'b1);
    chk("t1_hold_addr", bif1.oAddr, 12'h05C);
    bif1.req0 = 1'b0;
    step();
    chk("t1_idle_ack0", bif1.ack0, 1'b0);
    chk("t1_idle_busy", bif1.busy, 1'b0);

    // Both requesters held: grants alternate 0,1,0,1
    rst = 1'b1; step(); rst = 1'b0;
    bif1.addr0 = 12'h05C; bif1.data0 = 8'h30;
    bif1.addr1 = 12'h06B; bif1.data1 = 8'h4D;
    bif1.req0 = 1'b1; bif1.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (!(bif1.ack0 === 1'b1 || bif1.ack1 === 1'b1) && n < 8);
      chk("t2_gap", n, (i == 0) ? 3 : 4);
      chk("t2_ack0", bif1.ack0, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("t2_ack1", bif1.ack1, (i % 2 == 1) ? 1'b1 : 1'b0);
      chk("t2_addr", bif1.oAddr, (i % 2 == 1) ? 12'h06B : 12'h05C);
      chk("t2_data", bif1.oData, (i % 2 == 1) ? 8'h4D : 8'h30);
      if (i == 3) begin
        bif1.req0 = 1'b0; bif1.req1 = 1'b0;
      end
    end
    step();
    chk("t2_idle_busy", bif1.busy, 1'b0);
    chk("t2_idle_ack", {bif1.ack0, bif1.ack1}, 2'b00);

    // Clear pulsed at reset exit
    rst = 1'b1; step();
    rst = 1'b0; bif1.clr_req = 1'b1;
    nw = 0; nd = 0; bad = 0; done_at = 0;
    for (int k = 1; k <= 7210; k++) begin
      step();
      if (k == 1) bif1.clr_req = 1'b0;
      if (bif1.oNwr === 1'b0) begin
        if (bif1.oAddr !== nw[11:0] || bif1.oData !== 8'h20) bad++;
        nw++;
      end
      if (k <= 7200 && bif1.busy !== 1'b1) bad++;
      if (bif1.ack0 === 1'b1 || bif1.ack1 === 1'b1) bad++;
      if (bif1.clr_done === 1'b1) begin
        nd++;
        if (nd == 1) done_at = k;
      end
    end
    chk("t3_writes", nw, 2400);
    chk("t3_bad", bad, 0);
    chk("t3_done_count", nd, 1);
    chk("t3_done_at", done_at, 7201);
    chk("t3_end_busy", bif1.busy, 1'b0);

    // req1 raised during a clear
    bif1.clr_req = 1'b1;
    done_at = 0; ack_at = 0; glitch = 0; early = 0; nw = 0;
    prev_nwr = 1'b1; ack_addr = '0; ack_data = '0;
    for (int k = 1; k <= 7300; k++) begin
      step();
      if (k == 1) bif1.clr_req = 1'b0;
      if (k == 10) begin
        bif1.addr1 = 12'h06B; bif1.data1 = 8'h55; bif1.req1 = 1'b1;
      end
      if (bif1.oNwr === 1'b0) nw++;
      if (bif1.oNwr === 1'b0 && prev_nwr === 1'b0) glitch++;
      prev_nwr = bif1.oNwr;
      if (bif1.ack0 === 1'b1) early++;
      if (bif1.clr_done === 1'b1 && done_at == 0) done_at = k;
      if (bif1.ack1 === 1'b1) begin
        if (done_at == 0) early++;
        ack_at = k; ack_addr = bif1.oAddr; ack_data = bif1.oData;
        bif1.req1 = 1'b0;
        break;
      end
    end
    chk("t4_early_ack", early, 0);
    chk("t4_glitch", glitch, 0);
    chk("t4_strobes", nw, 2401);
    chk("t4_done_at", done_at, 7201);
    chk("t4_ack1_at", ack_at, 7204);
    chk("t4_ack1_addr", ack_addr, 12'h06B);
    chk("t4_ack1_data", ack_data, 8'h55);

    // Reset while in STROBE aborts the write and re-favours req0
    step();
    bif1.addr0 = 12'h123; bif1.data0 = 8'h77; bif1.req0 = 1'b1;
    step();
    step();
    chk("t5_in_strobe", bif1.oNwr, 1'b0);
    rst = 1'b1;
    bif1.addr1 = 12'h0AA; bif1.data1 = 8'h11; bif1.req1 = 1'b1;
    step();
    chk("t5_rst_nwr", bif1.oNwr, 1'b1);
    chk("t5_rst_busy", bif1.busy, 1'b0);
    chk("t5_rst_acks", {bif1.ack0, bif1.ack1}, 2'b00);
    chk("t5_rst_addr", bif1.oAddr, 12'h000);
    rst = 1'b0;
    step();
    chk("t5_regrant_addr", bif1.oAddr, 12'h123);
    step();
    chk("t5_regrant_nwr", bif1.oNwr, 1'b0);
    step();
    chk("t5_regrant_ack0", bif1.ack0, 1'b1);
    chk("t5_regrant_ack1", bif1.ack1, 1'b0);
    bif1.req0 = 1'b0; bif1.req1 = 1'b0;
    step();
    chk("t5_end_busy", bif1.busy, 1'b0);

    // Three-cycle strobe build, single req1
    bif3.addr1 = 12'h06B; bif3.data1 = 8'h42; bif3.req1 = 1'b1;
    lows = 0; ack_at = 0; first_low = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (bif3.oNwr === 1'b0) begin
        lows++;
        if (first_low == 0) first_low = k;
      end
      if (bif3.ack1 === 1'b1 && ack_at == 0) begin
        ack_at = k;
        bif3.req1 = 1'b0;
        chk("t6_hold_addr", bif3.oAddr, 12'h06B);
        chk("t6_hold_data", bif3.oData, 8'h42);
      end
    end
    chk("t6_low_cycles", lows, 3);
    chk("t6_first_low", first_low, 2);
    chk("t6_ack1_at", ack_at, 5);
    chk("t6_ack0", bif3.ack0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
